// File: rtl/fir_pkg.sv
// Shared types and default widths for the FIR job scheduler.
package fir_pkg;

  localparam int IN_SAMPLE_WIDTH  = 16;
  localparam int OUT_SAMPLE_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COEF = 2'd1,
    RUN  = 2'd2
  } fir_sched_state_t;

endpackage

// File: rtl/fir_watchdog.sv
// Job watchdog: counts cycles spent in RUN and emits a single expire pulse once
// TIMEOUT_CYCLES have elapsed since the job was launched.
module fir_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_r;
  logic          expire_r;

  // Count never wraps: enable drops the cycle after expire fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r  <= '0;
      expire_r <= 1'b0;
    end else if (clear) begin
      count_r  <= '0;
      expire_r <= 1'b0;
    end else if (enable) begin
      count_r  <= count_r + CW'(1);
      expire_r <= (count_r == LAST);
    end else begin
      expire_r <= 1'b0;
    end
  end

  assign expire = expire_r;

endmodule

// File: rtl/fir_job_scheduler.sv
// Arbitrates the shared FIR engine between sample-packet jobs and coefficient loads,
// with a one-entry pending buffer, a job watchdog and a delayed result return path.
module fir_job_scheduler #(
  parameter int SAMPLES_NUM      = 8,
  parameter int IN_SAMPLE_WIDTH  = fir_pkg::IN_SAMPLE_WIDTH,
  parameter int OUT_SAMPLE_WIDTH = fir_pkg::OUT_SAMPLE_WIDTH,
  parameter int TIMEOUT_CYCLES   = 4096,
  parameter int DROP_CNT_WIDTH   = 8
) (
  input  logic                                  clkIn,
  input  logic                                  resetIn,
  input  logic                                  sampleReadyIn,
  input  logic [IN_SAMPLE_WIDTH*SAMPLES_NUM-1:0]  sampleDataIn,
  input  logic                                  coefLoadIn,
  input  logic                                  coefWriteIn,
  input  logic [IN_SAMPLE_WIDTH*SAMPLES_NUM-1:0]  coefDataIn,
  input  logic                                  filterDoneIn,
  input  logic [OUT_SAMPLE_WIDTH*SAMPLES_NUM-1:0] filterResultIn,
  output logic                                  filterStartOut,
  output logic [IN_SAMPLE_WIDTH*SAMPLES_NUM-1:0]  filterDataOut,
  output logic                                  filterLoadOut,
  output logic                                  filterWriteOut,
  output logic [IN_SAMPLE_WIDTH*SAMPLES_NUM-1:0]  filterCoefOut,
  output logic [OUT_SAMPLE_WIDTH*SAMPLES_NUM-1:0] txDataOut,
  output logic                                  readyOut,
  output logic                                  overrunOut,
  output logic [DROP_CNT_WIDTH-1:0]             dropCountOut
);

  import fir_pkg::fir_sched_state_t;
  import fir_pkg::IDLE;
  import fir_pkg::COEF;
  import fir_pkg::RUN;

  localparam int IW = IN_SAMPLE_WIDTH * SAMPLES_NUM;
  localparam int OW = OUT_SAMPLE_WIDTH * SAMPLES_NUM;

  fir_sched_state_t state_r, state_nxt;

  logic [IW-1:0]             pending_r;
  logic                      pending_full_r;
  logic                      pending_full_nxt;
  logic [OW-1:0]             result_r;
  logic                      start_r;
  logic [IW-1:0]             fdata_r;
  logic                      load_r;
  logic                      write_r;
  logic [IW-1:0]             coef_r;
  logic [OW-1:0]             tx_r;
  logic                      ready_r;
  logic                      overrun_r;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_r;

  logic launch_s;
  logic done_s;
  logic timeout_s;
  logic drop_s;
  logic latch_s;
  logic run_s;
  logic expire_s;

  assign run_s = (state_r == RUN);

  fir_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clkIn),
    .rst   (resetIn),
    .clear (launch_s),
    .enable(run_s),
    .expire(expire_s)
  );

  // Next-state logic; a coefficient load outranks a pending job in IDLE.
  always_comb begin
    state_nxt = state_r;
    launch_s  = 1'b0;
    done_s    = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (coefLoadIn) begin
          state_nxt = COEF;
        end else if (pending_full_r) begin
          state_nxt = RUN;
          launch_s  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      COEF: begin
        if (!coefLoadIn) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = COEF;
        end
      end
      RUN: begin
        if (filterDoneIn) begin
          done_s    = 1'b1;
          state_nxt = IDLE;
        end else if (expire_s) begin
          timeout_s = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // A launch frees the entry in the same cycle, so a coincident packet is latched, not dropped.
  assign latch_s          = sampleReadyIn && (!pending_full_r || launch_s);
  assign drop_s           = sampleReadyIn && pending_full_r && !launch_s;
  assign pending_full_nxt = sampleReadyIn ? 1'b1 : (launch_s ? 1'b0 : pending_full_r);

  // State register.
  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Pending entry, job launch and result capture.
  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      pending_r      <= '0;
      pending_full_r <= 1'b0;
      start_r        <= 1'b0;
      fdata_r        <= '0;
      result_r       <= '0;
      tx_r           <= '0;
    end else begin
      pending_full_r <= pending_full_nxt;
      start_r        <= launch_s;
      if (latch_s) begin
        pending_r <= sampleDataIn;
      end
      if (launch_s) begin
        fdata_r <= pending_r;
      end
      // tx samples the buffer before this cycle's done/timeout update lands.
      if (sampleReadyIn) begin
        tx_r <= result_r;
      end
      if (done_s) begin
        result_r <= filterResultIn;
      end else if (timeout_s) begin
        result_r <= '0;
      end
    end
  end

  // Coefficient path, readiness and error reporting.
  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      load_r     <= 1'b0;
      write_r    <= 1'b0;
      coef_r     <= '0;
      ready_r    <= 1'b0;
      overrun_r  <= 1'b0;
      drop_cnt_r <= '0;
    end else begin
      load_r  <= (state_nxt == COEF);
      write_r <= (state_r == COEF) && coefWriteIn;
      if ((state_r == COEF) && coefWriteIn) begin
        coef_r <= coefDataIn;
      end
      ready_r <= (state_nxt != COEF) && !pending_full_nxt;
      if (drop_s || timeout_s) begin
        overrun_r <= 1'b1;
      end
      if (drop_s && (drop_cnt_r != {DROP_CNT_WIDTH{1'b1}})) begin
        drop_cnt_r <= drop_cnt_r + DROP_CNT_WIDTH'(1);
      end
    end
  end

  assign filterStartOut = start_r;
  assign filterDataOut  = fdata_r;
  assign filterLoadOut  = load_r;
  assign filterWriteOut = write_r;
  assign filterCoefOut  = coef_r;
  assign txDataOut      = tx_r;
  assign readyOut       = ready_r;
  assign overrunOut     = overrun_r;
  assign dropCountOut   = drop_cnt_r;

endmodule

// File: tb/tb_fir_job_scheduler.sv
// Directed self-checking bench for fir_job_scheduler with a small behavioural FIR model.
module tb_fir_job_scheduler;

  localparam int N   = 8;
  localparam int IW  = 16;
  localparam int OW  = 32;
  localparam int TO  = 256;
  localparam int DW  = 8;
  localparam int IWN = IW * N;
  localparam int OWN = OW * N;

  logic           clkIn = 1'b0;
  logic           resetIn;
  logic           sampleReadyIn;
  logic [IWN-1:0] sampleDataIn;
  logic           coefLoadIn;
  logic           coefWriteIn;
  logic [IWN-1:0] coefDataIn;
  logic           filterDoneIn;
  logic [OWN-1:0] filterResultIn;
  logic           filterStartOut;
  logic [IWN-1:0] filterDataOut;
  logic           filterLoadOut;
  logic           filterWriteOut;
  logic [IWN-1:0] filterCoefOut;
  logic [OWN-1:0] txDataOut;
  logic           readyOut;
  logic           overrunOut;
  logic [DW-1:0]  dropCountOut;

  int errors = 0;
  int checks = 0;

  int             fir_latency = 20;
  logic [OWN-1:0] fir_result = '0;
  logic           fir_busy = 1'b0;
  int             fir_cnt = 0;

  fir_job_scheduler #(
    .SAMPLES_NUM(N), .IN_SAMPLE_WIDTH(IW), .OUT_SAMPLE_WIDTH(OW),
    .TIMEOUT_CYCLES(TO), .DROP_CNT_WIDTH(DW)
  ) dut (
    .clkIn(clkIn), .resetIn(resetIn),
    .sampleReadyIn(sampleReadyIn), .sampleDataIn(sampleDataIn),
    .coefLoadIn(coefLoadIn), .coefWriteIn(coefWriteIn), .coefDataIn(coefDataIn),
    .filterDoneIn(filterDoneIn), .filterResultIn(filterResultIn),
    .filterStartOut(filterStartOut), .filterDataOut(filterDataOut),
    .filterLoadOut(filterLoadOut), .filterWriteOut(filterWriteOut),
    .filterCoefOut(filterCoefOut), .txDataOut(txDataOut), .readyOut(readyOut),
    .overrunOut(overrunOut), .dropCountOut(dropCountOut)
  );

  always #5 clkIn = ~clkIn;

  // FIR model: sees a start pulse, answers done after fir_latency cycles (0 = never).
  initial begin
    filterDoneIn   = 1'b0;
    filterResultIn = '0;
    forever begin
      @(posedge clkIn);
      #2;
      filterDoneIn = 1'b0;
      if (fir_busy) begin
        fir_cnt = fir_cnt + 1;
        if (fir_latency != 0 && fir_cnt >= fir_latency) begin
          filterDoneIn   = 1'b1;
          filterResultIn = fir_result;
          fir_busy       = 1'b0;
        end
      end
      if (filterStartOut) begin
        fir_busy = 1'b1;
        fir_cnt  = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  function automatic logic [IWN-1:0] mk_in(input logic [IW-1:0] base);
    logic [IWN-1:0] p;
    for (int i = 0; i < N; i++) p[i*IW +: IW] = base + IW'(i);
    return p;
  endfunction

  function automatic logic [OWN-1:0] mk_out(input logic [OW-1:0] base);
    logic [OWN-1:0] p;
    for (int i = 0; i < N; i++) p[i*OW +: OW] = base + OW'(i);
    return p;
  endfunction

  task automatic tick();
    @(negedge clkIn);
  endtask

  task automatic send(input logic [IWN-1:0] d);
    sampleReadyIn = 1'b1;
    sampleDataIn  = d;
    tick();
    sampleReadyIn = 1'b0;
  endtask

  task automatic do_reset();
    resetIn = 1'b1;
    repeat (3) tick();
    resetIn = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [4:0] st;
    resetIn = 1'b1; sampleReadyIn = 1'b0; sampleDataIn = '0; coefLoadIn = 1'b0;
    coefWriteIn = 1'b0; coefDataIn = '0;
    repeat (3) tick();
    st = {filterStartOut, filterLoadOut, filterWriteOut, readyOut, overrunOut};
    checks++;
    if (st !== 5'b00000 || dropCountOut !== 8'd0 || txDataOut !== '0 || filterDataOut !== '0 || filterCoefOut !== '0) begin
      errors++; $display("FAIL reset_values: got ctl=%b drop=%0d expected ctl=00000 drop=0, data 0", st, dropCountOut);
    end
    resetIn = 1'b0;
    tick();
    checks++;
    if (readyOut !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", readyOut); end
    for (int c = 0; c < 10; c++) begin
      tick();
      st = {filterStartOut, filterLoadOut, filterWriteOut, readyOut, overrunOut};
      checks++;
      if (st !== 5'b00010 || dropCountOut !== 8'd0 || txDataOut !== '0) begin
        errors++; $display("FAIL idle_outputs: cycle %0d got ctl=%b expected 00010", c, st);
      end
    end
  endtask

  task automatic test_single();
    logic [IWN-1:0] pa;
    pa = mk_in(16'h0001);
    fir_latency = 20;
    fir_result  = mk_out(32'hAAAA_0000);
    send(pa);
    checks++;
    if (filterStartOut !== 1'b0) begin errors++; $display("FAIL start_early: got %b expected 0", filterStartOut); end
    checks++;
    if (txDataOut !== '0) begin errors++; $display("FAIL tx_first: got %h expected 0", txDataOut); end
    tick();
    checks++;
    if (filterStartOut !== 1'b1 || filterDataOut !== pa) begin
      errors++; $display("FAIL start_latency: got start=%b data=%h expected 1 %h", filterStartOut, filterDataOut, pa);
    end
    repeat (30) tick();
    fir_result = mk_out(32'hBBBB_0000);
    send(mk_in(16'h0011));
    checks++;
    if (txDataOut !== mk_out(32'hAAAA_0000)) begin
      errors++; $display("FAIL tx_result_a: got %h expected %h", txDataOut, mk_out(32'hAAAA_0000));
    end
    repeat (30) tick();
    fir_result = mk_out(32'hCCCC_0000);
    send(mk_in(16'h0021));
    checks++;
    if (txDataOut !== mk_out(32'hBBBB_0000)) begin
      errors++; $display("FAIL tx_result_b: got %h expected %h", txDataOut, mk_out(32'hBBBB_0000));
    end
    repeat (30) tick();
  endtask

  task automatic test_back_to_back();
    logic [IWN-1:0] p1, p2, p3;
    int done_at, start_at;
    bit found;
    p1 = mk_in(16'h0100); p2 = mk_in(16'h0200); p3 = mk_in(16'h0300);
    fir_latency = 50;
    fir_result  = mk_out(32'h5000_0000);
    sampleReadyIn = 1'b1;
    sampleDataIn = p1; tick();
    sampleDataIn = p2; tick();
    checks++;
    if (filterStartOut !== 1'b1 || filterDataOut !== p1) begin
      errors++; $display("FAIL b2b_first_start: got start=%b data=%h expected 1 %h", filterStartOut, filterDataOut, p1);
    end
    sampleDataIn = p3; tick();
    sampleReadyIn = 1'b0;
    checks++;
    if (dropCountOut !== 8'd1 || overrunOut !== 1'b1 || readyOut !== 1'b0) begin
      errors++; $display("FAIL b2b_drop: got drop=%0d ovr=%b rdy=%b expected 1 1 0", dropCountOut, overrunOut, readyOut);
    end
    done_at = -100; start_at = 0; found = 1'b0;
    for (int c = 0; c < 120 && !found; c++) begin
      tick();
      if (filterDoneIn) done_at = c;
      if (filterStartOut) begin found = 1'b1; start_at = c; end
    end
    checks++;
    if (!found || (start_at - done_at) != 2 || filterDataOut !== p2) begin
      errors++; $display("FAIL b2b_second_start: got found=%b gap=%0d data=%h expected 1 2 %h", found, start_at - done_at, filterDataOut, p2);
    end
    repeat (70) tick();
  endtask

  task automatic test_coef();
    logic [IWN-1:0] pk, cw;
    pk = mk_in(16'h0700);
    fir_latency = 10;
    sampleReadyIn = 1'b1; sampleDataIn = pk; tick();
    sampleReadyIn = 1'b0; coefLoadIn = 1'b1; tick();
    checks++;
    if (filterStartOut !== 1'b0 || filterLoadOut !== 1'b1 || readyOut !== 1'b0) begin
      errors++; $display("FAIL coef_enter: got start=%b load=%b rdy=%b expected 0 1 0", filterStartOut, filterLoadOut, readyOut);
    end
    for (int k = 0; k < 4; k++) begin
      cw = mk_in(16'h1234 + IW'(k * 256));
      coefWriteIn = 1'b1; coefDataIn = cw; tick();
      coefWriteIn = 1'b0;
      checks++;
      if (filterWriteOut !== 1'b1 || filterCoefOut !== cw) begin
        errors++; $display("FAIL coef_write%0d: got wr=%b data=%h expected 1 %h", k, filterWriteOut, filterCoefOut, cw);
      end
      tick();
      checks++;
      if (filterWriteOut !== 1'b0 || filterStartOut !== 1'b0) begin
        errors++; $display("FAIL coef_write_pulse%0d: got wr=%b start=%b expected 0 0", k, filterWriteOut, filterStartOut);
      end
    end
    sampleReadyIn = 1'b1; sampleDataIn = mk_in(16'hDE00);
    repeat (300) tick();
    sampleReadyIn = 1'b0;
    checks++;
    if (dropCountOut !== 8'hFF) begin errors++; $display("FAIL drop_saturate: got %0d expected 255", dropCountOut); end
    coefLoadIn = 1'b0; tick();
    checks++;
    if (filterLoadOut !== 1'b0 || filterStartOut !== 1'b0) begin
      errors++; $display("FAIL coef_exit: got load=%b start=%b expected 0 0", filterLoadOut, filterStartOut);
    end
    tick();
    checks++;
    if (filterStartOut !== 1'b1 || filterDataOut !== pk) begin
      errors++; $display("FAIL coef_pending_start: got start=%b data=%h expected 1 %h", filterStartOut, filterDataOut, pk);
    end
    coefWriteIn = 1'b1; coefDataIn = mk_in(16'h4444); tick();
    coefWriteIn = 1'b0;
    checks++;
    if (filterWriteOut !== 1'b0) begin errors++; $display("FAIL coef_outside: got wr=%b expected 0", filterWriteOut); end
    repeat (20) tick();
  endtask

  task automatic test_timeout();
    int hit;
    do_reset();
    fir_latency = 10;
    fir_result  = mk_out(32'h7700_0000);
    send(mk_in(16'h0900));
    repeat (20) tick();
    fir_latency = 0;
    send(mk_in(16'h0A00));
    checks++;
    if (txDataOut !== mk_out(32'h7700_0000)) begin
      errors++; $display("FAIL to_tx_before: got %h expected %h", txDataOut, mk_out(32'h7700_0000));
    end
    tick();
    hit = 0;
    for (int c = 1; c <= TO + 20 && hit == 0; c++) begin
      tick();
      if (overrunOut) hit = c;
    end
    checks++;
    if (hit < TO || hit > TO + 2 || readyOut !== 1'b1) begin
      errors++; $display("FAIL timeout_abort: got cycle=%0d rdy=%b expected %0d..%0d 1", hit, readyOut, TO, TO + 2);
    end
    fir_latency = 10;
    send(mk_in(16'h0B00));
    checks++;
    if (txDataOut !== '0) begin errors++; $display("FAIL to_tx_zero: got %h expected 0", txDataOut); end
    repeat (20) tick();
  endtask

  task automatic test_reset_mid_run();
    bit started;
    do_reset();
    fir_latency = 30;
    fir_result  = mk_out(32'h3300_0000);
    send(mk_in(16'h0C00));
    tick();
    repeat (5) tick();
    resetIn = 1'b1;
    #1;
    checks++;
    if (filterDataOut !== '0 || readyOut !== 1'b0) begin
      errors++; $display("FAIL reset_async: got data=%h rdy=%b expected 0 0", filterDataOut, readyOut);
    end
    tick(); tick();
    resetIn = 1'b0;
    started = 1'b0;
    repeat (40) begin
      tick();
      if (filterStartOut) started = 1'b1;
    end
    checks++;
    if (started || overrunOut !== 1'b0 || readyOut !== 1'b1) begin
      errors++; $display("FAIL late_done_idle: got start=%b ovr=%b rdy=%b expected 0 0 1", started, overrunOut, readyOut);
    end
    send(mk_in(16'h0D00));
    checks++;
    if (txDataOut !== '0) begin errors++; $display("FAIL late_done_tx: got %h expected 0", txDataOut); end
    repeat (20) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_coef();
    test_timeout();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
